// File: rtl/lfsr_fifo_pkg.sv
// Shared definitions for the LFSR-addressed FIFO: legal pointer widths,
// the operation encoding and the feedback function used by the pointers.
package lfsr_fifo_pkg;

  localparam int MIN_ADDR_BITS = 3;
  localparam int MAX_ADDR_BITS = 9;

  // What the FIFO actually does on a given edge once full/empty gating is applied.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } fifoOp_e;

  // Feedback bit for an n-bit shift-left LFSR. The lockup term injects the
  // all-zeros state so the sequence covers all 2**n values, not 2**n - 1.
  function automatic logic lfsrFeedback(input logic [MAX_ADDR_BITS-1:0] ptr,
                                        input int n);
    logic                     taps;
    logic [MAX_ADDR_BITS-1:0] lowMask;
    logic                     lockup;
    case (n)
      4:       taps = ptr[3] ^ ptr[2];
      5:       taps = ptr[4] ^ ptr[2];
      6:       taps = ptr[5] ^ ptr[4];
      7:       taps = ptr[6] ^ ptr[5];
      8:       taps = ptr[7] ^ ptr[5] ^ ptr[4] ^ ptr[3];
      9:       taps = ptr[8] ^ ptr[4];
      default: taps = ptr[2] ^ ptr[1];
    endcase
    lowMask = (MAX_ADDR_BITS'(1) << (n - 1)) - MAX_ADDR_BITS'(1);
    lockup  = ~|(ptr & lowMask);
    return taps ^ lockup;
  endfunction

endpackage

// File: rtl/lfsr_fifo_ptr.sv
// Full-cycle LFSR pointer, seeded to all ones, stepping only when advanced.
module lfsr_ptr
  import lfsr_fifo_pkg::*;
#(
  parameter int ADDR_BITS = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 advance,
  output logic [ADDR_BITS-1:0] ptr,
  output logic [ADDR_BITS-1:0] ptr_next
);

  logic [ADDR_BITS-1:0] ptr_q;
  logic [ADDR_BITS-1:0] ptr_d;
  logic                 fb;

  // Successor state of the LFSR and the held-or-advanced next value.
  always_comb begin
    fb       = lfsrFeedback(MAX_ADDR_BITS'(ptr_q), ADDR_BITS);
    ptr_next = {ptr_q[ADDR_BITS-2:0], fb};
    ptr_d    = advance ? ptr_next : ptr_q;
  end

  // Pointer register; reset returns it to the all-ones seed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q <= '1;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/lfsr_fifo.sv
// Synchronous FIFO whose storage is addressed directly by LFSR pointers,
// with registered read data and one-cycle error pulses for rejected requests.
module lfsr_fifo
  import lfsr_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     din,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_valid,
  output logic                 full,
  output logic                 empty,
  output logic [ADDR_BITS:0]   count,
  output logic                 wr_err,
  output logic                 rd_err
);

  localparam int                 DEPTH       = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_COUNT = (ADDR_BITS + 1)'(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];

  logic [ADDR_BITS-1:0] wrPtr;
  logic [ADDR_BITS-1:0] rdPtr;
  logic [ADDR_BITS-1:0] wrPtrNext;
  logic [ADDR_BITS-1:0] rdPtrNext;
  logic                 unusedPtrNext;

  logic                 wrAccept;
  logic                 rdAccept;
  fifoOp_e              op;

  logic [ADDR_BITS:0]   count_q;
  logic [ADDR_BITS:0]   count_d;
  logic [WIDTH-1:0]     dout_q;
  logic [WIDTH-1:0]     dout_d;
  logic                 doutValid_q;
  logic                 wrErr_q;
  logic                 rdErr_q;

  assign full  = (count_q == DEPTH_COUNT);
  assign empty = (count_q == '0);

  assign wrAccept = wr_en && !full;
  assign rdAccept = rd_en && !empty;
  assign op       = fifoOp_e'({wrAccept, rdAccept});

  lfsr_ptr #(.ADDR_BITS(ADDR_BITS)) uWrPtr (
    .clock    (clock),
    .reset    (reset),
    .advance  (wrAccept),
    .ptr      (wrPtr),
    .ptr_next (wrPtrNext)
  );

  lfsr_ptr #(.ADDR_BITS(ADDR_BITS)) uRdPtr (
    .clock    (clock),
    .reset    (reset),
    .advance  (rdAccept),
    .ptr      (rdPtr),
    .ptr_next (rdPtrNext)
  );

  // Storage is addressed by the current pointers, so the look-ahead values go unused here.
  assign unusedPtrNext = ^{wrPtrNext, rdPtrNext};

  // Occupancy and read-data next state; simultaneous read+write leaves count alone.
  always_comb begin
    count_d = count_q;
    case (op)
      OP_WRITE: count_d = count_q + 1'b1;
      OP_READ:  count_d = count_q - 1'b1;
      default:  count_d = count_q;
    endcase
    dout_d = rdAccept ? mem[rdPtr] : dout_q;
  end

  // Memory array is deliberately not reset; empty hides stale contents.
  always_ff @(posedge clock) begin
    if (wrAccept) begin
      mem[wrPtr] <= din;
    end
  end

  // Registered status, read data and error pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      dout_q      <= '0;
      doutValid_q <= 1'b0;
      wrErr_q     <= 1'b0;
      rdErr_q     <= 1'b0;
    end else begin
      count_q     <= count_d;
      dout_q      <= dout_d;
      doutValid_q <= rdAccept;
      wrErr_q     <= wr_en && full;
      rdErr_q     <= rd_en && empty;
    end
  end

  assign count      = count_q;
  assign dout       = dout_q;
  assign dout_valid = doutValid_q;
  assign wr_err     = wrErr_q;
  assign rd_err     = rdErr_q;

endmodule

// File: tb/tb_lfsr_fifo.sv
// Bench for lfsr_fifo: a directed ADDR_BITS=3 instance and a randomized
// ADDR_BITS=8 instance, both checked every cycle against queue models.
module tb_lfsr_fifo;

  logic       clock = 1'b0;

  logic       rst3n = 1'b0;
  logic       wr3   = 1'b0;
  logic       rd3   = 1'b0;
  logic [7:0] din3  = 8'h00;
  logic [7:0] dout3;
  logic       dv3, full3, empty3, wrErr3, rdErr3;
  logic [3:0] count3;

  logic       rst8n = 1'b0;
  logic       wr8   = 1'b0;
  logic       rd8   = 1'b0;
  logic [7:0] din8  = 8'h00;
  logic [7:0] dout8;
  logic       dv8, full8, empty8, wrErr8, rdErr8;
  logic [8:0] count8;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q3[$];
  logic [7:0] q8[$];
  logic [7:0] e3Dout = 8'h00, e8Dout = 8'h00;
  logic       e3Valid = 1'b0, e3WrErr = 1'b0, e3RdErr = 1'b0;
  logic       e8Valid = 1'b0, e8WrErr = 1'b0, e8RdErr = 1'b0;
  logic       sawFull8 = 1'b0;

  logic [2:0] ptrSeq [8];
  logic [7:0] drainSeq [7];

  lfsr_fifo #(.WIDTH(8), .ADDR_BITS(3)) dut3 (
    .clock(clock), .reset(rst3n), .wr_en(wr3), .din(din3), .rd_en(rd3),
    .dout(dout3), .dout_valid(dv3), .full(full3), .empty(empty3),
    .count(count3), .wr_err(wrErr3), .rd_err(rdErr3)
  );

  lfsr_fifo #(.WIDTH(8), .ADDR_BITS(8)) dut8 (
    .clock(clock), .reset(rst8n), .wr_en(wr8), .din(din8), .rd_en(rd8),
    .dout(dout8), .dout_valid(dv8), .full(full8), .empty(empty8),
    .count(count8), .wr_err(wrErr8), .rd_err(rdErr8)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at edge+2: drive dut3 inputs, let one edge take them, return at edge+2.
  task automatic applyStimulus(input logic wr, input logic [7:0] d, input logic rd);
    wr3  = wr;
    din3 = d;
    rd3  = rd;
    @(posedge clock);
    #2;
  endtask

  // Asynchronous reset empties the models immediately.
  always @(negedge rst3n) begin
    q3.delete();
    e3Dout = 8'h00; e3Valid = 1'b0; e3WrErr = 1'b0; e3RdErr = 1'b0;
  end

  always @(negedge rst8n) begin
    q8.delete();
    e8Dout = 8'h00; e8Valid = 1'b0; e8WrErr = 1'b0; e8RdErr = 1'b0;
  end

  // Queue models step on each edge from the sampled requests; outputs compared 1 time unit later.
  always @(posedge clock) begin : compareProc
    int sz;
    if (!rst3n) begin
      q3.delete();
      e3Dout = 8'h00; e3Valid = 1'b0; e3WrErr = 1'b0; e3RdErr = 1'b0;
    end else begin
      sz      = q3.size();
      e3WrErr = wr3 && (sz == 8);
      e3RdErr = rd3 && (sz == 0);
      e3Valid = rd3 && (sz != 0);
      if (e3Valid) e3Dout = q3.pop_front();
      if (wr3 && sz < 8) q3.push_back(din3);
    end
    if (!rst8n) begin
      q8.delete();
      e8Dout = 8'h00; e8Valid = 1'b0; e8WrErr = 1'b0; e8RdErr = 1'b0;
    end else begin
      sz      = q8.size();
      e8WrErr = wr8 && (sz == 256);
      e8RdErr = rd8 && (sz == 0);
      e8Valid = rd8 && (sz != 0);
      if (e8Valid) e8Dout = q8.pop_front();
      if (wr8 && sz < 256) q8.push_back(din8);
    end
    #1;
    checkOutput("dout3",  dout3,  e3Dout);
    checkOutput("valid3", dv3,    e3Valid);
    checkOutput("wrErr3", wrErr3, e3WrErr);
    checkOutput("rdErr3", rdErr3, e3RdErr);
    checkOutput("count3", count3, q3.size());
    checkOutput("full3",  full3,  q3.size() == 8);
    checkOutput("empty3", empty3, q3.size() == 0);
    checkOutput("dout8",  dout8,  e8Dout);
    checkOutput("valid8", dv8,    e8Valid);
    checkOutput("wrErr8", wrErr8, e8WrErr);
    checkOutput("rdErr8", rdErr8, e8RdErr);
    checkOutput("count8", count8, q8.size());
    checkOutput("full8",  full8,  q8.size() == 256);
    checkOutput("empty8", empty8, q8.size() == 0);
    checkOutput("count8Bound", count8 <= 9'd256, 1);
    if (full8) sawFull8 = 1'b1;
  end

  initial begin
    ptrSeq   = '{3'b111, 3'b110, 3'b100, 3'b000, 3'b001, 3'b010, 3'b101, 3'b011};
    drainSeq = '{8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};

    repeat (3) @(posedge clock);
    #2;
    checkOutput("resetCount3", count3, 0);
    checkOutput("resetEmpty3", empty3, 1);
    checkOutput("resetFull3",  full3,  0);
    checkOutput("resetWrPtr3", dut3.wrPtr, 3'b111);
    rst3n = 1'b1;
    rst8n = 1'b1;
    @(posedge clock);
    #2;

    $display("[TB] eight writes from reset, pointer sequence");
    for (int i = 0; i < 8; i++) begin
      checkOutput("wrPtrSeq", dut3.wrPtr, ptrSeq[i]);
      checkOutput("fullBeforeLast", full3, 0);
      applyStimulus(1'b1, 8'(i + 1), 1'b0);
    end
    checkOutput("wrPtrWrap", dut3.wrPtr, 3'b111);
    checkOutput("fullAfter8", full3, 1);
    checkOutput("countAfter8", count3, 8);

    $display("[TB] write while full");
    applyStimulus(1'b1, 8'hEE, 1'b0);
    checkOutput("wrErrPulse", wrErr3, 1);
    checkOutput("countStay8", count3, 8);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("wrErrOneCycle", wrErr3, 0);

    $display("[TB] read back eight words");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("readOrder", dout3, 8'(i + 1));
      checkOutput("readValid", dv3, 1);
    end
    checkOutput("emptyAfterDrain", empty3, 1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("validOneCycle", dv3, 0);
    checkOutput("doutHold", dout3, 8'h08);

    $display("[TB] read while empty");
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("rdErrPulse", rdErr3, 1);
    checkOutput("noValidOnEmpty", dv3, 0);
    checkOutput("doutHoldEmpty", dout3, 8'h08);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("rdErrOneCycle", rdErr3, 0);

    $display("[TB] simultaneous read and write");
    applyStimulus(1'b1, 8'h11, 1'b1);
    checkOutput("bothEmptyCount", count3, 1);
    checkOutput("bothEmptyRdErr", rdErr3, 1);
    checkOutput("bothEmptyValid", dv3, 0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0);
    checkOutput("countIs3", count3, 3);
    applyStimulus(1'b1, 8'h44, 1'b1);
    checkOutput("bothMidCount", count3, 3);
    checkOutput("bothMidDout", dout3, 8'h11);
    checkOutput("bothMidValid", dv3, 1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h55 + i * 8'h11), 1'b0);
    checkOutput("refilled", count3, 8);
    applyStimulus(1'b1, 8'hFF, 1'b1);
    checkOutput("bothFullCount", count3, 7);
    checkOutput("bothFullWrErr", wrErr3, 1);
    checkOutput("bothFullDout", dout3, 8'h22);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("drainOrder", dout3, drainSeq[i]);
    end
    checkOutput("drainedEmpty", empty3, 1);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("countIs5", count3, 5);
    rst3n = 1'b0;
    #1;
    checkOutput("asyncCount", count3, 0);
    checkOutput("asyncEmpty", empty3, 1);
    checkOutput("asyncFull", full3, 0);
    checkOutput("asyncWrPtr", dut3.wrPtr, 3'b111);
    checkOutput("asyncRdPtr", dut3.rdPtr, 3'b111);
    #1;
    rst3n = 1'b1;
    @(posedge clock);
    #2;
    applyStimulus(1'b1, 8'hA5, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("postResetData", dout3, 8'hA5);
    checkOutput("postResetValid", dv3, 1);
    applyStimulus(1'b0, 8'h00, 1'b0);

    $display("[TB] random traffic on 256-entry instance");
    for (int c = 0; c < 10000; c++) begin
      int wrPct;
      wrPct = (((c / 1000) % 2) == 0) ? 70 : 30;
      wr8  = ($urandom_range(0, 99) < wrPct);
      rd8  = ($urandom_range(0, 99) < (100 - wrPct));
      din8 = 8'($urandom);
      @(posedge clock);
      #2;
    end
    wr8 = 1'b0;
    rd8 = 1'b0;
    @(posedge clock);
    #2;
    checkOutput("sawFull8", sawFull8, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
